// File: rtl/cache_nway.sv
// cache_nway: N-way set-associative write-back, write-allocate cache, true LRU.
// Ports:
//   clk, reset (async, active-high)
//   cpu_req_valid/cpu_req_ready, cpu_cmd, cpu_addr, cpu_wdata  : CPU request
//   cpu_resp_valid, cpu_rdata                                  : CPU completion
//   mem_cmd, mem_addr, mem_wdata, mem_resp, mem_rdata          : line-based memory bus
//   hit_count, miss_count                                      : only when CACHE_STATS_EN is defined
// Optional feature macro: CACHE_STATS_EN (hit/miss counters).
module cache_nway #(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned BUS_W      = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cpu_req_valid,
  output logic                                  cpu_req_ready,
  input  logic [2:0]                            cpu_cmd,
  input  logic [ADDR_W-1:0]                     cpu_addr,
  input  logic [31:0]                           cpu_wdata,
  output logic                                  cpu_resp_valid,
  output logic [31:0]                           cpu_rdata,
  output logic [1:0]                            mem_cmd,
  output logic [ADDR_W-$clog2(LINE_BYTES)-1:0]  mem_addr,
  output logic [BUS_W-1:0]                      mem_wdata,
  input  logic                                  mem_resp,
  input  logic [BUS_W-1:0]                      mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                           hit_count,
  output logic [31:0]                           miss_count
`endif
);

  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned SET_W  = $clog2(SETS);
  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - SET_W;
  localparam int unsigned BEATS  = LINE_BYTES * 8 / BUS_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BPB    = BUS_W / 8;

  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd2;
  localparam logic [1:0] MEM_WRITE = 2'd3;

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, EVICT_ACK, FILL_REQ, FILL, RESPOND} state_t;

  state_t state_q, state_d;

  logic [7:0]        data_q  [WAYS][SETS][LINE_BYTES];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [WAY_W-1:0]  age_q   [WAYS][SETS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];

  logic [2:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [WAY_W-1:0]  way_q, way_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              capt_q;

  logic [SET_W-1:0]  set_w;
  logic [TAG_W-1:0]  tag_w;
  logic [OFF_W-1:0]  off_w;
  logic              is_rd, is_wr, is_inv;
  logic [2:0]        nbytes;
  logic [ADDR_W-1:0] align_mask;

  assign set_w  = addr_q[OFF_W +: SET_W];
  assign tag_w  = addr_q[ADDR_W-1 -: TAG_W];
  assign off_w  = addr_q[OFF_W-1:0];
  assign is_inv = (cmd_q == 3'd4);
  assign is_wr  = cmd_q[2] && (cmd_q[1:0] != 2'd0);
  assign is_rd  = !cmd_q[2] && (cmd_q[1:0] != 2'd0);
  assign nbytes = (cmd_q[1:0] == 2'd1) ? 3'd1 : (cmd_q[1:0] == 2'd2) ? 3'd2 : 3'd4;
  // Natural alignment: clear addr[0] for 16-bit, addr[1:0] for 32-bit accesses.
  assign align_mask = (cpu_cmd[1:0] == 2'd2) ? ADDR_W'(1) :
                      (cpu_cmd[1:0] == 2'd3) ? ADDR_W'(3) : '0;

  function automatic logic [OFF_W-1:0] byte_idx(input logic [BEAT_W-1:0] b, input int j);
    return OFF_W'(int'(b) * int'(BPB) + j);
  endfunction

  // Tag lookup, first invalid way, and oldest way in the addressed set.
  logic             hit, inv_found;
  logic [WAY_W-1:0] hit_way, inv_way, lru_way, max_age, victim;
  always_comb begin
    hit = 1'b0; hit_way = '0; inv_found = 1'b0; inv_way = '0; lru_way = '0; max_age = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_w][w] && (tag_q[w][set_w] == tag_w) && !hit) begin
        hit = 1'b1; hit_way = WAY_W'(w);
      end
      if (!valid_q[set_w][w] && !inv_found) begin
        inv_found = 1'b1; inv_way = WAY_W'(w);
      end
      if (age_q[w][set_w] > max_age) begin
        max_age = age_q[w][set_w]; lru_way = WAY_W'(w);
      end
    end
    victim = inv_found ? inv_way : lru_way;
  end

  // Read data at the aligned offset, zero-extended.
  logic [31:0] rd_val;
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < 4; i++)
      if (3'(i) < nbytes) rd_val[i*8 +: 8] = data_q[hit_way][set_w][off_w + OFF_W'(i)];
  end

  logic fill_cap, fill_last;
  assign fill_cap  = (state_q == FILL) && (capt_q || mem_resp);
  assign fill_last = fill_cap && (beat_q == BEAT_W'(BEATS - 1));

  // Next state, working way/beat and response data.
  logic [31:0] rdata_d;
  always_comb begin
    state_d = state_q;
    way_d   = way_q;
    beat_d  = beat_q;
    rdata_d = '0;
    case (state_q)
      IDLE:      if (cpu_req_valid && (cpu_cmd != 3'd0)) state_d = LOOKUP;
      LOOKUP: begin
        if (is_inv) begin
          if (hit && dirty_q[set_w][hit_way]) begin
            state_d = EVICT; way_d = hit_way; beat_d = '0;
          end else begin
            state_d = RESPOND;
          end
        end else if (hit) begin
          state_d = RESPOND; way_d = hit_way;
          if (is_rd) rdata_d = rd_val;
        end else begin
          way_d  = victim;
          beat_d = '0;
          state_d = (valid_q[set_w][victim] && dirty_q[set_w][victim]) ? EVICT : FILL_REQ;
        end
      end
      EVICT: begin
        if (beat_q == BEAT_W'(BEATS - 1)) state_d = EVICT_ACK;
        else beat_d = beat_q + 1'b1;
      end
      EVICT_ACK: if (mem_resp) state_d = is_inv ? RESPOND : FILL_REQ;
      FILL_REQ: begin
        state_d = FILL; beat_d = '0;
      end
      // After the last beat the line is installed and re-looked-up, which then hits.
      FILL: begin
        if (fill_cap) begin
          if (fill_last) state_d = LOOKUP;
          else beat_d = beat_q + 1'b1;
        end
      end
      RESPOND:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outgoing write-back beat for the next cycle.
  logic [BUS_W-1:0] ev_word;
  always_comb begin
    ev_word = '0;
    for (int j = 0; j < BPB; j++) ev_word[j*8 +: 8] = data_q[way_d][set_w][byte_idx(beat_d, j)];
  end

  // State, request latches and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cmd_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      way_q          <= '0;
      beat_q         <= '0;
      capt_q         <= 1'b0;
      cpu_req_ready  <= 1'b1;
      cpu_resp_valid <= 1'b0;
      cpu_rdata      <= '0;
      mem_cmd        <= MEM_NOP;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      beat_q  <= beat_d;
      if (state_q == IDLE && state_d == LOOKUP) begin
        cmd_q   <= cpu_cmd;
        addr_q  <= cpu_addr & ~align_mask;
        wdata_q <= cpu_wdata;
      end
      if (state_q == FILL_REQ) capt_q <= 1'b0;
      else if (state_q == FILL && mem_resp) capt_q <= 1'b1;
      cpu_req_ready  <= (state_d == IDLE);
      cpu_resp_valid <= (state_d == RESPOND);
      if (state_d == RESPOND) cpu_rdata <= rdata_d;
      case (state_d)
        EVICT: begin
          mem_cmd   <= MEM_WRITE;
          mem_addr  <= {tag_q[way_d][set_w], set_w};
          mem_wdata <= ev_word;
        end
        FILL_REQ: begin
          mem_cmd  <= MEM_READ;
          mem_addr <= {tag_w, set_w};
        end
        default: mem_cmd <= MEM_NOP;
      endcase
    end
  end

  // Line data and tags: fill beats, install tag, write merge.
  always_ff @(posedge clk) begin
    if (fill_cap) begin
      for (int j = 0; j < BPB; j++) data_q[way_q][set_w][byte_idx(beat_q, j)] <= mem_rdata[j*8 +: 8];
      if (fill_last) tag_q[way_q][set_w] <= tag_w;
    end
    if (state_q == LOOKUP && hit && is_wr) begin
      for (int i = 0; i < 4; i++)
        if (3'(i) < nbytes) data_q[hit_way][set_w][off_w + OFF_W'(i)] <= wdata_q[i*8 +: 8];
    end
  end

  // LRU: the installed way is treated as the oldest before being made youngest.
  logic             lru_en;
  logic [WAY_W-1:0] acc_way, acc_old;
  assign lru_en  = fill_last || (state_q == LOOKUP && hit && !is_inv);
  assign acc_way = fill_last ? way_q : hit_way;
  assign acc_old = fill_last ? WAY_W'(WAYS - 1) : age_q[hit_way][set_w];

  // Valid, dirty and age state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[w][s] <= '0;
      end
    end else begin
      if (state_q == FILL_REQ) begin
        valid_q[set_w][way_q] <= 1'b0;
        dirty_q[set_w][way_q] <= 1'b0;
      end
      if (fill_last) valid_q[set_w][way_q] <= 1'b1;
      if (state_q == LOOKUP && hit && is_wr) dirty_q[set_w][hit_way] <= 1'b1;
      if (state_q == LOOKUP && hit && is_inv && !dirty_q[set_w][hit_way])
        valid_q[set_w][hit_way] <= 1'b0;
      if (state_q == EVICT_ACK && mem_resp && is_inv) begin
        valid_q[set_w][way_q] <= 1'b0;
        dirty_q[set_w][way_q] <= 1'b0;
      end
      if (lru_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == acc_way) age_q[w][set_w] <= '0;
          else if (valid_q[set_w][w] && (age_q[w][set_w] < acc_old))
            age_q[w][set_w] <= age_q[w][set_w] + 1'b1;
        end
      end
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating hit/miss counters; the re-lookup after a fill is not counted again.
  logic refill_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refill_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state_q == IDLE) refill_q <= 1'b0;
      else if (fill_last) refill_q <= 1'b1;
      if (state_q == LOOKUP && !is_inv && !refill_q) begin
        if (hit) begin
          if (hit_count != '1) hit_count <= hit_count + 32'd1;
        end else begin
          if (miss_count != '1) miss_count <= miss_count + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: doc/cache_nway.md
CACHE_NWAY -- requirements
Module: cache_nway

Interface
REQ-001 SHALL have parameter WAYS, default 4, associativity (power of 2, 2..8).
REQ-002 SHALL have parameter SETS, default 16, number of sets (power of 2).
REQ-003 SHALL have parameter LINE_BYTES, default 16, line size in bytes (power of 2, at least 4).
REQ-004 SHALL have parameter ADDR_W, default 19, CPU byte-address width.
REQ-005 SHALL have parameter BUS_W, default 16, memory data-bus width; BEATS = LINE_BYTES*8/BUS_W.
REQ-006 SHALL have port: clk  in  1  clock, all logic on rising edge.
REQ-007 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port: cpu_req_valid  in  1  CPU request present.
REQ-009 SHALL have port: cpu_req_ready  out  1  cache accepts a request.
REQ-010 SHALL have port: cpu_cmd  in  3  1=RD8, 2=RD16, 3=RD32, 4=INV_LINE, 5=WR8, 6=WR16, 7=WR32; 0=NOP (ignored).
REQ-011 SHALL have ports: cpu_addr  in  ADDR_W  byte address; cpu_wdata  in  32  write data, LSB-aligned.
REQ-012 SHALL have ports: cpu_resp_valid  out  1  one-cycle completion pulse; cpu_rdata  out  32  read data, zero-extended.
REQ-013 SHALL have ports: mem_cmd  out  2  0=NOP, 2=READ, 3=WRITE; mem_addr  out  ADDR_W-log2(LINE_BYTES)  line address.
REQ-014 SHALL have ports: mem_wdata  out  BUS_W; mem_resp  in  1; mem_rdata  in  BUS_W.

Function
REQ-015 SHALL accept a request on a rising edge where cpu_req_valid and cpu_req_ready are both 1; cpu_req_ready SHALL be 1 only in IDLE.
REQ-016 SHALL latch cmd/addr/wdata at accept; address split is tag | set = addr[log2(LINE_BYTES) +: log2(SETS)] | offset.
REQ-017 SHALL ignore addr[0] for 16-bit accesses and addr[1:0] for 32-bit accesses, forcing natural alignment.
REQ-018 SHALL implement FSM states IDLE, LOOKUP, EVICT, EVICT_ACK, FILL_REQ, FILL, RESPOND; any other encoding SHALL return to IDLE.
REQ-019 SHALL, on hit, go IDLE->LOOKUP->RESPOND; cpu_resp_valid SHALL pulse exactly 2 cycles after the accept edge.
REQ-020 SHALL, on miss, select the lowest-index invalid way, otherwise the least-recently-used way.
REQ-021 SHALL, if the victim is valid and dirty, enter EVICT: drive mem_cmd=WRITE for BEATS consecutive cycles, victim line address, low beat first; then, in EVICT_ACK, hold mem_cmd=NOP until mem_resp=1.
REQ-022 SHALL, in FILL_REQ, drive mem_cmd=READ for one cycle; in FILL, capture mem_rdata on BEATS consecutive cycles starting with the first cycle mem_resp=1, low beat first.
REQ-023 SHALL install a filled line valid, clean, with the new tag; write misses SHALL allocate then merge, leaving the line dirty.
REQ-024 SHALL, on a write hit, merge the byte-enabled bytes and set dirty.
REQ-025 SHALL keep true LRU as a log2(WAYS)-bit age per way: the accessed way is set to age 0, and ways younger than its old age are incremented.
REQ-026 SHALL handle INV_LINE as follows: hit+dirty writes back (REQ-021) then clears valid; hit+clean clears valid; a miss performs no memory traffic; all cases end in RESPOND.
REQ-027 SHALL keep cpu_rdata stable from RESPOND until the next accept; it SHALL be 0 for writes and INV_LINE.
REQ-028 SHALL ignore mem_resp outside EVICT_ACK/FILL, and ignore cpu_req_valid while not ready.

Reset
REQ-029 SHALL, on reset (including mid-transaction), clear all valid, dirty and age bits, enter IDLE, and drop any in-flight request without a response.
REQ-030 SHALL drive reset outputs: cpu_req_ready=1 after release, cpu_resp_valid=0, cpu_rdata=0, mem_cmd=NOP, mem_addr=0, mem_wdata=0.

Configuration
REQ-031 SHALL, when CACHE_STATS_EN is defined, add outputs hit_count  out  32 and miss_count  out  32, saturating at all-ones, cleared by reset; these count only RD/WR accesses, one per accepted request, and exclude INV_LINE.
REQ-032 SHALL, when CACHE_STATS_EN is undefined, omit those ports and counters, with all other behaviour identical.

Verification
REQ-033 SHALL cover: after reset, RD16 at 0x00040 -> FILL_REQ with mem_addr=0x004, 8 beats captured, cpu_rdata = beat0; repeating the read -> resp 2 cycles after accept, no mem_cmd.
REQ-034 SHALL cover: WR8 data 0xA5 to 0x00043, then RD8 at 0x00043 -> 0x000000A5 with no memory traffic.
REQ-035 SHALL cover: fill 5 distinct tags into set 0 (WAYS=4) after dirtying the first -> EVICT writes the first line's 8 beats to its line address, then waits for mem_resp.
REQ-036 SHALL cover: INV_LINE on a dirty line -> write-back, then a subsequent read of the same address misses.
REQ-037 SHALL cover: reset asserted in the middle of FILL -> no cpu_resp_valid, mem_cmd=NOP, and the next read misses.
REQ-038 SHALL cover: with CACHE_STATS_EN, 3 misses and 2 hits -> miss_count=3, hit_count=2.
